key_pulse_conditioner: RTL and testbench

//  Input-side conditioner for a DE1-SoC pushbutton feeding a game strobe such as i_enter.
//  - Synchronises the raw key, which is asynchronous and active-low.
//  - Debounces it.
//  - Emits single-cycle press/release strobes plus a clean level.
//  One instance per KEY. Sits between the board pins and the game/control FSMs.

---
 rtl/key_pulse_conditioner.sv | 163 ++++++++++++++++
 tb/tb_key_pulse_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_conditioner.sv
// Pushbutton conditioner: two-flop synchroniser, debounce FSM, registered press/release strobes.
// Optional auto-repeat of o_press while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int KEY_ACTIVE_LOW       = 1,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  // o_press / o_release are one-cycle strobes with no back-pressure: the consumer must
  // sample them on every clock; o_level is the debounced pressed level.

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          key_pressed;
  logic          k_s;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          accept_press;
  logic          rep_fire;

  assign key_pressed = (KEY_ACTIVE_LOW != 0) ? ~i_key_raw : i_key_raw;
  assign k_s         = sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    level_d      = level_q;
    release_d    = 1'b0;
    accept_press = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (k_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!k_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d      = HELD;
          cnt_d        = '0;
          accept_press = 1'b1;
          level_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!k_s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (k_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RCW = $clog2(REP_MAX + 1);
  localparam logic [RCW-1:0] REP_DLY = RCW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCW-1:0] REP_PER = RCW'(REPEAT_PERIOD_CYCLES - 1);

  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_phase_q, rep_phase_d;

  // Repeat timer runs through HELD and RELEASE_WAIT; a release strobe wins over a repeat.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    if (accept_press) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if ((state_q == HELD || state_q == RELEASE_WAIT) && state_d != IDLE) begin
      if (rep_cnt_q == (rep_phase_q ? REP_PER : REP_DLY)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RCW'(1);
      end
    end else begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign press_d = accept_press | rep_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_pressed;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with DEBOUNCE_CYCLES=4 (strobe 6 edges after the raw change).
// Expected strobes (kind, cycle) are queued by the stimulus and popped by a negedge monitor.
module tb_key_pulse_conditioner;
  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic reset_n;
  logic i_key_raw;
  logic o_level, o_press, o_release;

  key_pulse_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW(1),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_PERIOD_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_key_raw(i_key_raw),
    .o_level(o_level),
    .o_press(o_press),
    .o_release(o_release)
  );

  // clock / cycle counter: at a negedge, cyc equals the number of posedges so far
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {kind (1=press,0=release), cycle}
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_strobe(input logic kind, input int c);
    exp_q.push_back({kind, 32'(c)});
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor
  logic        prev_strobe = 1'b0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (o_press || o_release) begin
      check("strobe_exclusive", 32'(o_press & o_release), 0);
      check("strobe_not_back_to_back", 32'(prev_strobe), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_strobe: press=%0d release=%0d, none required (cycle %0d)",
                 o_press, o_release, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(o_press), 32'(e[32]));
        check("strobe_cycle", 32'(cyc), e[31:0]);
      end
    end
    prev_strobe = o_press | o_release;
  end

  initial begin
    #200000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: time limit reached at cycle %0d, required earlier finish", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  int t, p;
  initial begin
    reset_n   = 1'b0;
    i_key_raw = 1'b0;
    repeat (3) @(negedge clk);

    // 1: key held through reset release
    check("reset_level", 32'(o_level), 0);
    check("reset_press", 32'(o_press), 0);
    check("reset_release", 32'(o_release), 0);
    t = cyc;
    reset_n = 1'b1;
    expect_strobe(1'b1, t + LAT);
    goto(t + LAT - 1);
    check("t1_level_before", 32'(o_level), 0);
    goto(t + LAT);
    check("t1_level_after", 32'(o_level), 1);
    t = cyc;
    i_key_raw = 1'b1;
    expect_strobe(1'b0, t + LAT);
    goto(t + LAT);
    check("t1_level_released", 32'(o_level), 0);
    goto(cyc + 3);

    // 2: clean press and release
    t = cyc;
    i_key_raw = 1'b0;
    expect_strobe(1'b1, t + LAT);
    goto(t + LAT - 1);
    check("t2_level_before", 32'(o_level), 0);
    goto(t + LAT);
    check("t2_level_pressed", 32'(o_level), 1);
    goto(t + LAT + 1);
    t = cyc;
    i_key_raw = 1'b1;
    expect_strobe(1'b0, t + LAT);
    goto(t + LAT - 1);
    check("t2_level_still_held", 32'(o_level), 1);
    goto(t + LAT);
    check("t2_level_released", 32'(o_level), 0);
    goto(cyc + 3);

    // 3: bounce whose glitch lands on the completion cycle
    t = cyc;
    i_key_raw = 1'b0;
    goto(t + 3);
    i_key_raw = 1'b1;
    goto(t + 4);
    i_key_raw = 1'b0;
    expect_strobe(1'b1, t + 4 + LAT);
    goto(t + 4 + LAT - 1);
    check("t3_no_early_level", 32'(o_level), 0);
    goto(t + 4 + LAT);
    check("t3_level_pressed", 32'(o_level), 1);
    i_key_raw = 1'b1;
    expect_strobe(1'b0, t + 4 + 2 * LAT);
    goto(t + 4 + 2 * LAT);
    check("t3_level_released", 32'(o_level), 0);
    goto(cyc + 3);

    // 4: short release glitch while held
    t = cyc;
    i_key_raw = 1'b0;
    p = t + LAT;
    expect_strobe(1'b1, p);
    goto(p);
    i_key_raw = 1'b1;
    goto(p + 2);
    i_key_raw = 1'b0;
    goto(p + 6);
    check("t4_level_kept", 32'(o_level), 1);
`ifdef KEY_AUTOREPEAT_EN
    expect_strobe(1'b1, p + 10);
`endif
    i_key_raw = 1'b1;
    expect_strobe(1'b0, p + 6 + LAT);
    goto(p + 6 + LAT - 1);
    check("t4_level_before_release", 32'(o_level), 1);
    goto(p + 6 + LAT);
    check("t4_level_released", 32'(o_level), 0);
    goto(cyc + 3);

    // 5: reset in the middle of debounce
    t = cyc;
    i_key_raw = 1'b0;
    goto(t + 4);
    check("t5_state_press_wait", 32'(dut.state_q), 1);
    reset_n = 1'b0;
    goto(t + 5);
    check("t5_state_in_reset", 32'(dut.state_q), 0);
    check("t5_level_in_reset", 32'(o_level), 0);
    i_key_raw = 1'b1;
    goto(t + 6);
    reset_n = 1'b1;
    goto(t + 16);
    check("t5_state_after", 32'(dut.state_q), 0);
    check("t5_level_after", 32'(o_level), 0);

    // 6: long hold (auto-repeat strobes only with the macro)
    t = cyc;
    i_key_raw = 1'b0;
    expect_strobe(1'b1, t + LAT);
`ifdef KEY_AUTOREPEAT_EN
    expect_strobe(1'b1, t + 16);
    expect_strobe(1'b1, t + 19);
    expect_strobe(1'b1, t + 22);
    expect_strobe(1'b1, t + 25);
    expect_strobe(1'b1, t + 28);
    expect_strobe(1'b1, t + 31);
    expect_strobe(1'b1, t + 34);
`endif
    goto(t + 30);
    check("t6_level_held", 32'(o_level), 1);
    i_key_raw = 1'b1;
    expect_strobe(1'b0, t + 30 + LAT);
    goto(t + 30 + LAT);
    check("t6_level_released", 32'(o_level), 0);

    goto(cyc + 10);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
